// File: rtl/cpu_ext_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_ext_pkg: size/mode codes and alignment check for load-data extension   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cpu_ext_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_RSVD = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      EXT_ZERO  = 2'd0,
      EXT_SIGN  = 2'd1,
      EXT_UPPER = 2'd2,
      EXT_RSVD  = 2'd3
   } mode_e;

   // Offset is passed zero-extended so the check works for any datapath width.
   function automatic logic is_misaligned(input size_e size, input logic [7:0] off);
      logic r;
      r = 1'b0;
      case (size)
         SZ_BYTE: r = 1'b0;
         SZ_HALF: r = off[0];
         SZ_WORD: r = (off != 8'd0);
         default: r = 1'b1;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ext_lane_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ext_lane_core: combinational lane select, zero/sign/upper extension and    |
// | misalignment detection. Revision: 1.0                                      |
// +----------------------------------------------------------------------------+
module ext_lane_core
   import cpu_ext_pkg::*;
#(
   parameter int DATA_W = 32,
   localparam int OFF_W = $clog2(DATA_W/8)
) (
   input  logic [DATA_W-1:0] data,
   input  logic [OFF_W-1:0]  offset,
   input  logic [1:0]        size,
   input  logic [1:0]        mode,
   output logic [DATA_W-1:0] result,
   output logic              misalign
);

   localparam logic [DATA_W-1:0] c_BYTE_MASK = DATA_W'(8'hFF);
   localparam logic [DATA_W-1:0] c_HALF_MASK = DATA_W'(16'hFFFF);

   size_e               w_size;
   mode_e               w_mode;
   logic [DATA_W-1:0]   w_shifted;
   logic [DATA_W-1:0]   w_mask;
   logic [DATA_W-1:0]   w_ext;
   logic                w_sign;
   logic                w_mis;

   assign w_size    = size_e'(size);
   assign w_mode    = mode_e'(mode);
   assign w_shifted = data >> {offset, 3'b000};
   assign w_mis     = is_misaligned(w_size, 8'(offset));

   // Lane bits are kept by the mask; the complement of the mask is the fill region.
   always_comb begin
      w_mask = '1;
      w_sign = 1'b0;
      case (w_size)
         SZ_BYTE: begin
            w_mask = c_BYTE_MASK;
            w_sign = w_shifted[7];
         end
         SZ_HALF: begin
            w_mask = c_HALF_MASK;
            w_sign = w_shifted[15];
         end
         default: begin
            w_mask = '1;
            w_sign = 1'b0;
         end
      endcase
      w_ext = w_shifted & w_mask;
      if (w_mode == EXT_SIGN && w_sign)
         w_ext = w_ext | ~w_mask;
   end

   always_comb begin
      result   = '0;
      misalign = 1'b0;
      if (w_mode == EXT_UPPER) begin
         result   = {data[DATA_W/2-1:0], {(DATA_W/2){1'b0}}};
         misalign = 1'b0;
      end else if (w_mis) begin
         result   = '0;
         misalign = 1'b1;
      end else begin
         result   = w_ext;
         misalign = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/load_extend_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_extend_unit: registered load-data extension with a 2-entry skid       |
// | buffer on valid/ready handshakes. Revision: 1.0                            |
// +----------------------------------------------------------------------------+
module load_extend_unit
   import cpu_ext_pkg::*;
#(
   parameter int DATA_W = 32,
   localparam int OFF_W = $clog2(DATA_W/8)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [OFF_W-1:0]  in_offset,
   input  logic [1:0]        in_size,
   input  logic [1:0]        in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_misalign
);

   logic [DATA_W-1:0] w_res_data;
   logic              w_res_mis;
   logic              w_accept;
   logic              w_out_free;

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_mis;
   logic              r_skid_valid;
   logic [DATA_W-1:0] r_skid_data;
   logic              r_skid_mis;

   ext_lane_core #(
      .DATA_W (DATA_W)
   ) u_core (
      .data     (in_data),
      .offset   (in_offset),
      .size     (in_size),
      .mode     (in_mode),
      .result   (w_res_data),
      .misalign (w_res_mis)
   );

   assign in_ready   = !r_skid_valid;
   assign w_accept   = in_valid && !r_skid_valid;
   assign w_out_free = !r_out_valid || out_ready;

   // A full skid implies in_ready is low, so accept and skid drain never coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_mis    <= 1'b0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
         r_skid_mis   <= 1'b0;
      end else if (w_out_free) begin
         if (r_skid_valid) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= r_skid_data;
            r_out_mis    <= r_skid_mis;
            r_skid_valid <= 1'b0;
         end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_res_data;
            r_out_mis   <= w_res_mis;
         end else begin
            r_out_valid <= 1'b0;
         end
      end else if (w_accept) begin
         r_skid_valid <= 1'b1;
         r_skid_data  <= w_res_data;
         r_skid_mis   <= w_res_mis;
      end
   end

   assign out_valid    = r_out_valid;
   assign out_data     = r_out_data;
   assign out_misalign = r_out_mis;

endmodule
`default_nettype wire

// File: tb/tb_load_extend_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_load_extend_unit: scoreboard bench for load_extend_unit (DATA_W=32)     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_load_extend_unit;

   typedef struct packed {
      logic [31:0] data;
      logic        mis;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [1:0]  in_offset;
   logic [1:0]  in_size;
   logic [1:0]  in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_misalign;

   int   n_total = 0;
   int   n_bad   = 0;
   int   n_pops  = 0;
   int   cyc     = 0;
   exp_t sb_q[$];

   load_extend_unit #(.DATA_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_offset    (in_offset),
      .in_size      (in_size),
      .in_mode      (in_mode),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_misalign (out_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] d, input logic [1:0] off,
                                  input logic [1:0] sz, input logic [1:0] md);
      exp_t        e;
      logic [31:0] lane;
      logic [7:0]  b;
      logic [15:0] h;
      e.data = 32'h0;
      e.mis  = 1'b0;
      lane   = d >> (8 * int'(off));
      b      = lane[7:0];
      h      = lane[15:0];
      if (md == 2'd2) begin
         e.data = {d[15:0], 16'h0000};
      end else if (sz == 2'd3 || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0)) begin
         e.mis = 1'b1;
      end else begin
         case (sz)
            2'd0:    e.data = (md == 2'd1) ? {{24{b[7]}}, b} : {24'h0, b};
            2'd1:    e.data = (md == 2'd1) ? {{16{h[15]}}, h} : {16'h0, h};
            default: e.data = d;
         endcase
      end
      return e;
   endfunction

   // Compare delivered results, then record newly accepted requests.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            n_pops++;
            if (sb_q.size() == 0) begin
               chk("unexpected_out", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("sb_data", out_data, e.data);
               chk("sb_mis", {31'd0, out_misalign}, {31'd0, e.mis});
            end
         end
         if (in_valid && in_ready)
            sb_q.push_back(model(in_data, in_offset, in_size, in_mode));
      end
   end

   // Presents a request and returns just after the edge that accepted it; in_valid stays high.
   task automatic send(input logic [31:0] d, input logic [1:0] off,
                       input logic [1:0] sz, input logic [1:0] md);
      int   waited;
      logic ok;
      in_valid  = 1'b1;
      in_data   = d;
      in_offset = off;
      in_size   = sz;
      in_mode   = md;
      waited    = 0;
      ok        = 1'b0;
      while (!ok && waited < 200) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         waited++;
      end
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   logic rand_done;

   initial begin
      int p0;
      int c0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_offset = '0;
      in_size   = '0;
      in_mode   = '0;
      out_ready = 1'b1;
      rand_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_mis", {31'd0, out_misalign}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Byte sign-extend, one-cycle latency
      send(32'h1234_80FF, 2'd1, 2'd0, 2'd1);
      idle();
      @(negedge clk);
      chk("bsign_lat", {31'd0, out_valid}, 32'd1);
      chk("bsign_data", out_data, 32'hFFFF_FF80);
      chk("bsign_mis", {31'd0, out_misalign}, 32'd0);
      @(posedge clk);
      #1;

      send(32'hBEEF_1234, 2'd2, 2'd1, 2'd0);
      send(32'hBEEF_1234, 2'd3, 2'd1, 2'd0);
      idle();
      @(negedge clk);
      chk("half_mis_flag", {31'd0, out_misalign}, 32'd1);
      chk("half_mis_data", out_data, 32'd0);
      @(posedge clk);
      #1;

      send(32'h0000_ABCD, 2'd3, 2'd3, 2'd2);
      idle();
      @(negedge clk);
      chk("upper_data", out_data, 32'hABCD_0000);
      chk("upper_mis", {31'd0, out_misalign}, 32'd0);
      @(posedge clk);
      #1;

      // Back-pressure: A lands in output, B in skid
      out_ready = 1'b0;
      send(32'h0000_00AA, 2'd0, 2'd2, 2'd0);
      send(32'h0000_00BB, 2'd0, 2'd2, 2'd0);
      idle();
      @(negedge clk);
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_a", out_data, 32'h0000_00AA);
      @(posedge clk);
      #1;
      chk("bp_still_a", out_data, 32'h0000_00AA);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_out_a", out_data, 32'h0000_00AA);
      @(negedge clk);
      chk("bp_out_b_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_b", out_data, 32'h0000_00BB);
      chk("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Streaming words 0..7 with no bubble
      p0 = n_pops;
      c0 = cyc;
      for (int i = 0; i < 8; i++) send(32'(i), 2'd0, 2'd2, 2'd0);
      idle();
      chk("stream_cycles", 32'(cyc - c0), 32'd8);
      @(negedge clk);
      #1;
      chk("stream_pops", 32'(n_pops - p0), 32'd8);
      @(posedge clk);
      #1;

      // Random traffic with random back-pressure
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               send($urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)));
               if ($urandom_range(0, 3) == 0) begin
                  idle();
                  @(posedge clk);
                  #1;
               end
            end
            idle();
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 2) != 0);
            end
         end
      join
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("drain_empty", 32'(sb_q.size()), 32'd0);

      // Reset with A in output and B in skid
      out_ready = 1'b0;
      send(32'h0000_0A0A, 2'd0, 2'd2, 2'd0);
      send(32'h0000_0B0B, 2'd0, 2'd2, 2'd0);
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("no_replay", {31'd0, out_valid}, 32'd0);
      end
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
